// File: rtl/bpu_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_if_pc                        fetch PC looked up this cycle
//   o_pred_taken, o_pred_target    combinational fetch-stage prediction
//   i_ex_*                         resolved instruction in EX plus the prediction it carried
//   i_stat_clr                     synchronous clear of the statistics counters
//   o_mispred, o_redirect_pc       combinational flush request and corrected fetch PC
//   o_ctrl                         EX holds a valid branch or jump
//   o_br_cnt, o_miss_cnt           saturating resolved-control / mispredict counters
module bpu_btb #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 12,
  parameter int unsigned MODE    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_vld,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  input  logic        i_stat_clr,
  output logic        o_mispred,
  output logic [31:0] o_redirect_pc,
  output logic        o_ctrl,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam bit          DYN   = (MODE != 0);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(2 ** (CTR_W - 1) - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             ex_ctrl, ex_act_taken;
  logic [31:0]      act_next, pred_next;

  // Fetch lookup: pure read of current table contents, no bypass from EX.
  assign if_idx        = i_if_pc[IDX_W+1:2];
  assign if_tag        = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_hit        = DYN && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign o_pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
  assign o_pred_target = if_hit ? tgt_q[if_idx] : i_if_pc + 32'd4;

  // EX resolution: compare the next-PC the instruction needs with the one fetch assumed.
  assign ex_idx        = i_ex_pc[IDX_W+1:2];
  assign ex_tag        = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctrl       = i_ex_is_br | i_ex_is_jmp;
  assign ex_act_taken  = i_ex_is_jmp | (i_ex_is_br & i_ex_taken);
  assign act_next      = ex_act_taken ? i_ex_target : i_ex_pc + 32'd4;
  assign pred_next     = i_ex_pred_taken ? i_ex_pred_target : i_ex_pc + 32'd4;
  assign o_mispred     = i_ex_vld && (act_next != pred_next);
  assign o_redirect_pc = act_next;
  assign o_ctrl        = i_ex_vld & ex_ctrl;

  // Table update from EX; non-control hits are stale aliases and get dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (DYN && i_ex_vld) begin
      if (ex_ctrl) begin
        if (ex_hit) begin
          if (ex_act_taken) begin
            if (ctr_q[ex_idx] != CTR_MAX) ctr_q[ex_idx] <= ctr_q[ex_idx] + CTR_W'(1);
            tgt_q[ex_idx] <= i_ex_target;
          end else if (ctr_q[ex_idx] != '0) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - CTR_W'(1);
          end
        end else if (ex_act_taken) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= i_ex_target;
          ctr_q[ex_idx]   <= CTR_WT;
        end
      end else if (ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // Statistics: clear wins over increment, both counters stick at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_cnt   <= '0;
      o_miss_cnt <= '0;
    end else if (i_stat_clr) begin
      o_br_cnt   <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (o_ctrl && (o_br_cnt != 32'hFFFF_FFFF))      o_br_cnt   <= o_br_cnt + 32'd1;
      if (o_mispred && (o_miss_cnt != 32'hFFFF_FFFF)) o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end

endmodule
